// File: rtl/collision_scorekeeper_if.sv
// Signal bundle between the game-control stage and its neighbours.
// The highScore signal exists only when HIGH_SCORE_EN is defined.
interface collision_scorekeeper_if;
  logic                 start;
  logic [3:0]           ROW;
  logic [15:0][15:0]    GrnPixels;
  logic [15:0][15:0]    RedPixels;
  logic                 RUNen;
  logic                 hit;
  logic                 gameOver;
  logic [7:0]           score;
`ifdef HIGH_SCORE_EN
  logic [7:0]           highScore;
`endif

  modport master (
    output start, ROW, GrnPixels, RedPixels,
`ifdef HIGH_SCORE_EN
    input  highScore,
`endif
    input  RUNen, hit, gameOver, score
  );

  modport slave (
    input  start, ROW, GrnPixels, RedPixels,
`ifdef HIGH_SCORE_EN
    output highScore,
`endif
    output RUNen, hit, gameOver, score
  );
endinterface

// File: rtl/collision_scorekeeper.sv
// Collision detection, game FSM (idle/run/hit/over) and saturating BCD score keeper.
// Optional best-score register enabled by defining HIGH_SCORE_EN.
module collision_scorekeeper #(
  parameter int unsigned HIT_HOLD = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  collision_scorekeeper_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_OVER} state_e;

  localparam logic [7:0] HOLD_INIT = 8'(HIT_HOLD - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        start_q;
  logic [3:0]  row_q;
  logic        runen_q, runen_d;
  logic        hit_q, hit_d;
  logic        gameover_q, gameover_d;
  logic [7:0]  score_q, score_d;
  logic        overlap, wrap, start_edge;

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign overlap    = |(bus.GrnPixels & bus.RedPixels);
  assign wrap       = (row_q == 4'd15) && (bus.ROW == 4'd0);
  assign start_edge = bus.start && !start_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      hold_q     <= 8'd0;
      start_q    <= 1'b1;
      row_q      <= 4'd0;
      runen_q    <= 1'b0;
      hit_q      <= 1'b0;
      gameover_q <= 1'b0;
      score_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      start_q    <= bus.start;
      row_q      <= bus.ROW;
      runen_q    <= runen_d;
      hit_q      <= hit_d;
      gameover_q <= gameover_d;
      score_q    <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE, S_OVER: if (start_edge) state_d = S_RUN;
      S_RUN: begin
        if (overlap) begin
          state_d = S_HIT;
          hold_d  = HOLD_INIT;
        end
      end
      S_HIT: begin
        if (hold_q == 8'd0) state_d = S_OVER;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so that they are registered.
  always_comb begin
    runen_d    = (state_d == S_RUN);
    hit_d      = (state_q == S_RUN) && overlap;
    gameover_d = (state_d == S_OVER);
    score_d    = score_q;
    if ((state_q == S_IDLE || state_q == S_OVER) && start_edge)
      score_d = 8'h00;
    else if (state_q == S_RUN && !overlap && wrap)
      score_d = bcd_inc_sat(score_q);
  end

  assign bus.RUNen    = runen_q;
  assign bus.hit      = hit_q;
  assign bus.gameOver = gameover_q;
  assign bus.score    = score_q;

`ifdef HIGH_SCORE_EN
  logic [7:0] high_q, high_d;

  function automatic logic bcd_gt(input logic [7:0] a, input logic [7:0] b);
    logic r;
    if (a[7:4] != b[7:4]) r = (a[7:4] > b[7:4]);
    else                  r = (a[3:0] > b[3:0]);
    return r;
  endfunction

  always_comb begin
    high_d = high_q;
    if (state_q == S_HIT && state_d == S_OVER && bcd_gt(score_q, high_q))
      high_d = score_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) high_q <= 8'h00;
    else     high_q <= high_d;
  end

  assign bus.highScore = high_q;
`endif

endmodule

// File: tb/tb_collision_scorekeeper.sv
// Directed bench for collision_scorekeeper: vector table plus multi-cycle scenarios.
module tb_collision_scorekeeper;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  collision_scorekeeper_if bus();

  collision_scorekeeper #(.HIT_HOLD(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       start;
    logic [3:0] row;
    logic       ovl;
    logic       runen;
    logic       hit;
    logic       go;
    logic [7:0] score;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] r, input logic o);
    logic [15:0][15:0] g;
    logic [15:0][15:0] p;
    g = '0;
    p = '0;
    g[2][0]   = 1'b1;
    g[5][7]   = 1'b1;
    g[r][12]  = 1'b1;
    p[15][15] = 1'b1;
    p[0][1]   = 1'b1;
    p[5][7]   = o;
    bus.start     = s;
    bus.ROW       = r;
    bus.GrnPixels = g;
    bus.RedPixels = p;
  endtask

  task automatic step(input logic s, input logic [3:0] r, input logic o);
    drive(s, r, o);
    @(posedge CLK);
    #1;
  endtask

  task automatic wraps(input int n);
    for (int w = 0; w < n; w++) begin
      step(1'b0, 4'd15, 1'b0);
      step(1'b0, 4'd0, 1'b0);
    end
  endtask

  task automatic chk_outs(input string tag, input logic runen, input logic hit,
                          input logic go, input logic [7:0] score);
    chk({tag, "_runen"}, {7'd0, bus.RUNen}, {7'd0, runen});
    chk({tag, "_hit"},   {7'd0, bus.hit},   {7'd0, hit});
    chk({tag, "_go"},    {7'd0, bus.gameOver}, {7'd0, go});
    chk({tag, "_score"}, bus.score, score);
  endtask

  task automatic chk_high(input string tag, input logic [7:0] exp);
`ifdef HIGH_SCORE_EN
    chk({tag, "_high"}, bus.highScore, exp);
`else
    if (exp === 8'hxx) chk({tag, "_high"}, 8'h00, 8'h00);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //        start  row    ovl   runen  hit   go    score
    tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[6]  = '{1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[7]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h02};
    tbl[8]  = '{1'b0, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 8'h02};
    tbl[9]  = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[10] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[12] = '{1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 8'h02};
    tbl[13] = '{1'b0, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
    tbl[14] = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset with the start button held
    RST = 1'b1;
    drive(1'b1, 4'd0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    chk_high("reset", 8'h00);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].start, tbl[i].row, tbl[i].ovl);
      chk_outs($sformatf("v%0d", i), tbl[i].runen, tbl[i].hit, tbl[i].go, tbl[i].score);
    end
    chk_high("game1", 8'h02);

    // Ten full row sweeps: 10 wraps
    step(1'b0, 4'd15, 1'b0);
    for (int s = 0; s < 10; s++) begin
      for (int r = 0; r < 16; r++) begin
        step(1'b0, 4'(r), 1'b0);
        if (r == 0)
          chk($sformatf("sweep%0d", s), bus.score,
              8'((((s + 1) / 10) << 4) | ((s + 1) % 10)));
      end
    end
    chk("sweep_run", {7'd0, bus.RUNen}, 8'd1);

    // Collision at score 0x10, game over after hold window
    step(1'b0, 4'd5, 1'b1);
    chk_outs("coll2", 1'b0, 1'b1, 1'b0, 8'h10);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd5, 1'b0);
      chk_outs($sformatf("hold2_%0d", k), 1'b0, 1'b0, 1'b0, 8'h10);
    end
    step(1'b0, 4'd5, 1'b0);
    chk_outs("over2", 1'b0, 1'b0, 1'b1, 8'h10);
    chk_high("game2", 8'h10);

    // Overlap coincident with wrap at score 0x07
    step(1'b1, 4'd0, 1'b0);
    chk_outs("start3", 1'b1, 1'b0, 1'b0, 8'h00);
    wraps(7);
    chk("score7", bus.score, 8'h07);
    step(1'b0, 4'd15, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    chk_outs("wrapcoll", 1'b0, 1'b1, 1'b0, 8'h07);
    repeat (4) step(1'b0, 4'd1, 1'b0);
    chk_outs("over3", 1'b0, 1'b0, 1'b1, 8'h07);
    chk_high("game3", 8'h10);

    // Saturation at 0x99
    step(1'b1, 4'd0, 1'b0);
    chk_outs("start4", 1'b1, 1'b0, 1'b0, 8'h00);
    chk_high("start4", 8'h10);
    wraps(98);
    chk("score98", bus.score, 8'h98);
    wraps(1);
    chk("sat1", bus.score, 8'h99);
    wraps(1);
    chk("sat2", bus.score, 8'h99);
    wraps(1);
    chk("sat3", bus.score, 8'h99);
    step(1'b0, 4'd5, 1'b1);
    chk("coll4_hit", {7'd0, bus.hit}, 8'd1);
    repeat (4) step(1'b0, 4'd5, 1'b0);
    chk_outs("over4", 1'b0, 1'b0, 1'b1, 8'h99);
    chk_high("game4", 8'h99);
    step(1'b1, 4'd0, 1'b0);
    chk_outs("start5", 1'b1, 1'b0, 1'b0, 8'h00);
    chk_high("start5", 8'h99);
    wraps(2);
    chk("score5", bus.score, 8'h02);

    // Reset in RUN while start is pressed
    RST = 1'b1;
    step(1'b1, 4'd0, 1'b0);
    chk_outs("rstrun", 1'b0, 1'b0, 1'b0, 8'h00);
    chk_high("rstrun", 8'h00);
    RST = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    chk_outs("rsthold", 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    chk_outs("restart", 1'b1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_scorekeeper.md
# collision_scorekeeper

Game-control stage directly downstream of the asteroid frame generator. Each cycle it compares the 16x16 asteroid pixel frame against the player pixel frame, runs the game state machine (idle / run / hit / over), drives the run-enable that freezes asteroid motion, and keeps a two-digit BCD score of asteroid passes survived. Its outputs feed the LED-matrix driver (game-over flash) and the HEX display decoders.

## Interface
- HIT_HOLD, 4: cycles spent in HIT (flash window) before entering OVER; legal range 1..255.
- CLK  in  1  system clock; all state on posedge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  player start button, already synchronised; level input, rising edge used.
- ROW  in  4  current asteroid row index from the row sequencer.
- GrnPixels  in  [15:0][15:0]  asteroid frame, indexed [row][col].
- RedPixels  in  [15:0][15:0]  player frame, same indexing.
- RUNen  out  1  high only in RUN; enables row sequencer and asteroid generator.
- hit  out  1  one-cycle pulse on collision.
- gameOver  out  1  high in OVER.
- score  out  8  BCD score, [7:4] tens, [3:0] ones.
- highScore  out  8  BCD best score (only with HIGH_SCORE_EN).

## Operation
- overlap = OR-reduction of (GrnPixels & RedPixels) over all 256 bits; combinational, sampled each cycle.
- wrap = registered previous ROW == 15 and current ROW == 0.
- Start edge: start high and registered start_d low. start_d resets to 1, so a button held through reset does not start a game.
- States, transitions evaluated each cycle:
  - IDLE: RUNen=0. Start edge -> RUN, score cleared to 0x00.
  - RUN: RUNen=1. overlap -> HIT, hit pulses. Else wrap -> score increments. Start edges ignored.
  - HIT: RUNen=0. Hold counter loads HIT_HOLD-1 on entry and decrements each cycle; at 0 -> OVER. Start edges and overlap ignored.
  - OVER: gameOver=1, RUNen=0, score held. Start edge -> RUN, score cleared, gameOver drops.
- Score arithmetic: BCD. Ones 9 -> 0 with tens+1. Saturates at 0x99; no wrap to 00.
- If overlap and wrap occur in the same RUN cycle, the collision wins: no increment.
- overlap outside RUN never pulses hit and never changes state.

## Timing
- All outputs registered. Reset values: state IDLE, RUNen 0, hit 0, gameOver 0, score 0x00, highScore 0x00, start_d 1, hold counter 0.
- RST mid-game: next cycle all outputs at reset values regardless of state; RST dominates start.
- Start edge seen at cycle N in IDLE/OVER: RUNen=1 and score=0 at N+1.
- overlap at cycle N in RUN: hit=1 and RUNen=0 at N+1, hit=0 at N+2.
- First HIT cycle is N+1. gameOver=1 at N+1+HIT_HOLD.
- wrap at cycle N: score updated at N+1.
- The upstream sequencer freezes as soon as RUNen falls. One further ROW advance may already be in flight; it is harmless because HIT ignores wrap.

## Configuration
- HIGH_SCORE_EN defined:
  - Adds the highScore port and register.
  - On the transition into OVER, highScore <= score if score > highScore (BCD compare, tens then ones).
  - Cleared only by RST; survives new games.
- Undefined: no highScore port, no register. All other behaviour identical.

## Test plan
- Reset with start held high, then RST released: no game starts. Release start, press again: RUNen=1 next cycle, score=0x00.
- RUN, ROW sweeps 0..15 ten times with no overlap: score reaches 0x10. Ones digit passes 0x09 -> 0x10 correctly.
- RUN, set GrnPixels[5][7]=RedPixels[5][7]=1 at cycle N: hit=1 only at N+1, RUNen=0 at N+1, gameOver=1 at N+5 (HIT_HOLD=4).
- overlap asserted in the same cycle as a ROW 15->0 wrap with score 0x07: score stays 0x07, state HIT.
- Force score 0x98, three clean wraps: score 0x99 and holds. Assert RST in RUN: all outputs zero next cycle.
- HIGH_SCORE_EN: game 1 ends at 0x12, game 2 at 0x05. highScore=0x12 after both; a new start leaves highScore unchanged.
